// File: rtl/vga_vram_arbiter.sv
// Single-port VRAM arbiter for a 160x120x3 framebuffer shown as 640x480 VGA.
// Display reads own every 4th active cycle; the host writes in whatever cycles are left.
module vga_vram_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  hcnt_i,
  input  logic [9:0]  vcnt_i,
  input  logic        wr_req_i,
  input  logic [14:0] wr_addr_i,
  input  logic [2:0]  wr_data_i,
  input  logic        wr_vblank_only_i,
  output logic        wr_ack_o,
  output logic [14:0] ram_addr_o,
  output logic        ram_we_o,
  output logic        ram_re_o,
  output logic [2:0]  ram_wdata_o,
  input  logic [2:0]  ram_rdata_i,
  output logic        hsync_o,
  output logic        vsync_o,
  output logic        r_o,
  output logic        g_o,
  output logic        b_o,
  output logic        oob_err_o,
  input  logic        oob_clr_i
);

  localparam logic [9:0]  H_ACTIVE  = 10'd640;
  localparam logic [9:0]  V_ACTIVE  = 10'd480;
  localparam logic [9:0]  HS_START  = 10'd656;
  localparam logic [9:0]  HS_END    = 10'd751;
  localparam logic [9:0]  VS_START  = 10'd490;
  localparam logic [9:0]  VS_END    = 10'd491;
  localparam logic [14:0] FB_W      = 15'd160;
  localparam logic [14:0] FB_PIXELS = 15'd19200;

  logic        active, slot, eligible, grant, in_range, oob_set;
  logic        hs_now, vs_now;
  logic [14:0] disp_addr;

  assign active    = (hcnt_i < H_ACTIVE) && (vcnt_i < V_ACTIVE);
  assign slot      = active && (hcnt_i[1:0] == 2'b00);
  assign eligible  = !slot && (!wr_vblank_only_i || (vcnt_i >= V_ACTIVE));
  assign grant     = eligible && wr_req_i;
  assign in_range  = wr_addr_i < FB_PIXELS;
  assign oob_set   = grant && !in_range;
  assign disp_addr = {7'd0, vcnt_i[9:2]} * FB_W + {7'd0, hcnt_i[9:2]};

  // Out-of-range requests are still acknowledged so the host never stalls on them.
  assign wr_ack_o    = grant;
  assign ram_re_o    = slot;
  assign ram_we_o    = grant && in_range;
  assign ram_wdata_o = wr_data_i;
  assign ram_addr_o  = slot ? disp_addr : wr_addr_i;

  assign hs_now = !((hcnt_i >= HS_START) && (hcnt_i <= HS_END));
  assign vs_now = !((vcnt_i >= VS_START) && (vcnt_i <= VS_END));

  logic       act_s1_q, slot_s1_q, hs_s1_q, vs_s1_q;
  logic [2:0] pix_q, pix_d;
  logic [2:0] rgb_q, rgb_d;
  logic       hsync_q, vsync_q;
  logic       oob_q, oob_d;

  // Forwarding ram_rdata into rgb_d lets the pixel reach the pins in the same
  // edge that loads the hold register, giving the 2-cycle raster-to-pixel latency.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    pix_d = pix_q;
    rgb_d = 3'b000;
    oob_d = oob_q;
    if (slot_s1_q) pix_d = ram_rdata_i;
    if (act_s1_q)  rgb_d = pix_d;
    if (oob_clr_i) oob_d = 1'b0;
    if (oob_set)   oob_d = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      act_s1_q  <= 1'b0;
      slot_s1_q <= 1'b0;
      hs_s1_q   <= 1'b1;
      vs_s1_q   <= 1'b1;
      pix_q     <= 3'b000;
      rgb_q     <= 3'b000;
      hsync_q   <= 1'b1;
      vsync_q   <= 1'b1;
      oob_q     <= 1'b0;
    end else begin
      act_s1_q  <= active;
      slot_s1_q <= slot;
      hs_s1_q   <= hs_now;
      vs_s1_q   <= vs_now;
      pix_q     <= pix_d;
      rgb_q     <= rgb_d;
      hsync_q   <= hs_s1_q;
      vsync_q   <= vs_s1_q;
      oob_q     <= oob_d;
    end
  end

  assign {r_o, g_o, b_o} = rgb_q;
  assign hsync_o   = hsync_q;
  assign vsync_o   = vsync_q;
  assign oob_err_o = oob_q;

endmodule

// File: tb/tb_vga_vram_arbiter.sv
// Scoreboard bench for vga_vram_arbiter: display outputs are predicted two cycles
// ahead and RAM writes are predicted per cycle, both drained as the DUT produces them.
module tb_vga_vram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  hcnt, vcnt;
  logic        wr_req, wr_vblank_only, wr_ack;
  logic [14:0] wr_addr, ram_addr;
  logic [2:0]  wr_data, ram_wdata, ram_rdata;
  logic        ram_we, ram_re;
  logic        hsync, vsync, r, g, b, oob_err, oob_clr;

  always #5 clk = ~clk;

  vga_vram_arbiter dut (
    .clk(clk), .rst(rst), .hcnt_i(hcnt), .vcnt_i(vcnt),
    .wr_req_i(wr_req), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .wr_vblank_only_i(wr_vblank_only), .wr_ack_o(wr_ack),
    .ram_addr_o(ram_addr), .ram_we_o(ram_we), .ram_re_o(ram_re),
    .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata),
    .hsync_o(hsync), .vsync_o(vsync), .r_o(r), .g_o(g), .b_o(b),
    .oob_err_o(oob_err), .oob_clr_i(oob_clr)
  );

  typedef struct packed { logic [2:0] rgb; logic hs; logic vs; } disp_t;
  typedef struct packed { logic [14:0] a; logic [2:0] d; } wr_t;
  localparam disp_t RST_E = '{rgb: 3'b000, hs: 1'b1, vs: 1'b1};

  int n_checks = 0;
  int n_pass   = 0;
  disp_t exp_q[$];
  wr_t   wq[$];
  wr_t   w_pop;
  logic [2:0] mem [0:19199];
  logic [2:0] cur_pix;
  logic       exp_oob;

  // Stimulus for the next cycle; step() applies it at the falling edge.
  int         h, v;
  logic       req_v, vbo_v, clr_v, rst_v;
  logic [14:0] addr_v;
  logic [2:0]  data_v;

  // RAM model: 1-cycle read latency, writes checked against the expected-write queue.
  always @(posedge clk) begin
    if (ram_re && ram_addr < 15'd19200) ram_rdata <= mem[ram_addr];
    if (ram_we) begin
      n_checks++;
      if (wq.size() == 0) begin
        $display("FAIL ram_write unexpected: addr=%0d data=%b, none expected", ram_addr, ram_wdata);
      end else begin
        w_pop = wq.pop_front();
        if (ram_addr !== w_pop.a || ram_wdata !== w_pop.d)
          $display("FAIL ram_write: got addr=%0d data=%b, exp addr=%0d data=%b",
                   ram_addr, ram_wdata, w_pop.a, w_pop.d);
        else n_pass++;
      end
      if (ram_addr < 15'd19200) mem[ram_addr] <= ram_wdata;
    end
  end

  task automatic step();
    disp_t e, got;
    logic act, slot, elig, grant, inr, e_we;
    logic [14:0] da;
    @(negedge clk);
    e   = exp_q.pop_front();
    got = '{rgb: {r, g, b}, hs: hsync, vs: vsync};
    n_checks++;
    if (got !== e)
      $display("FAIL display (inputs h=%0d v=%0d): got rgb=%b hs=%b vs=%b, exp rgb=%b hs=%b vs=%b",
               h, v, got.rgb, got.hs, got.vs, e.rgb, e.hs, e.vs);
    else n_pass++;
    n_checks++;
    if (oob_err !== exp_oob) $display("FAIL oob_err (h=%0d v=%0d): got %b exp %b", h, v, oob_err, exp_oob);
    else n_pass++;

    if (rst === 1'b1 && !rst_v) begin
      exp_q.delete();
      exp_q.push_back(RST_E);
    end
    hcnt = h[9:0]; vcnt = v[9:0];
    wr_req = req_v; wr_addr = addr_v; wr_data = data_v;
    wr_vblank_only = vbo_v; oob_clr = clr_v; rst = rst_v;
    #1;
    act   = (h < 640) && (v < 480);
    slot  = act && (h % 4 == 0);
    elig  = !slot && (!vbo_v || v >= 480);
    grant = elig && req_v;
    inr   = addr_v < 15'd19200;
    e_we  = grant && inr;
    da    = 15'((v / 4) * 160 + (h / 4));

    n_checks++;
    if (wr_ack !== grant) $display("FAIL wr_ack (h=%0d v=%0d): got %b exp %b", h, v, wr_ack, grant);
    else n_pass++;
    n_checks++;
    if (ram_we !== e_we) $display("FAIL ram_we (h=%0d v=%0d): got %b exp %b", h, v, ram_we, e_we);
    else n_pass++;
    n_checks++;
    if (ram_re !== slot) $display("FAIL ram_re (h=%0d v=%0d): got %b exp %b", h, v, ram_re, slot);
    else n_pass++;
    if (slot) begin
      n_checks++;
      if (ram_addr !== da) $display("FAIL ram_addr_disp (h=%0d v=%0d): got %0d exp %0d", h, v, ram_addr, da);
      else n_pass++;
    end
    if (e_we) begin
      n_checks++;
      if (ram_addr !== addr_v || ram_wdata !== data_v)
        $display("FAIL ram_addr_wr (h=%0d v=%0d): got %0d/%b exp %0d/%b", h, v, ram_addr, ram_wdata, addr_v, data_v);
      else n_pass++;
      wq.push_back('{a: addr_v, d: data_v});
    end

    if (!rst_v) begin
      exp_q.push_back(RST_E);
      cur_pix = 3'b000;
      exp_oob = 1'b0;
    end else begin
      if (slot) cur_pix = mem[da];
      e.rgb = act ? cur_pix : 3'b000;
      e.hs  = !(h >= 656 && h <= 751);
      e.vs  = !(v >= 490 && v <= 491);
      exp_q.push_back(e);
      if (grant && !inr) exp_oob = 1'b1;
      else if (clr_v)    exp_oob = 1'b0;
    end
  endtask

  task automatic adv();
    h++;
    if (h == 800) begin
      h = 0;
      v = (v == 524) ? 0 : v + 1;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      adv();
    end
  endtask

  task automatic test_reset();
    h = 0; v = 0; rst_v = 1'b0;
    step();
    n_checks++;
    if ({r, g, b} !== 3'b000 || hsync !== 1'b1 || vsync !== 1'b1 || oob_err !== 1'b0)
      $display("FAIL reset_values: got rgb=%b hs=%b vs=%b oob=%b", {r, g, b}, hsync, vsync, oob_err);
    else n_pass++;
    adv();
    run(4);
    h = 8; rst_v = 1'b1;
    run(40);
  endtask

  task automatic test_display();
    h = 796; v = 524;
    while (!(h == 2 && v == 0)) begin step(); adv(); end
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++;
      if ({r, g, b} !== 3'b101) $display("FAIL first_pixel h=%0d: got %b exp 101", h, {r, g, b});
      else n_pass++;
      adv();
    end
    run(800);
  endtask

  task automatic test_slot_vs_host();
    h = 8; v = 4; req_v = 1'b1; addr_v = 15'd500; data_v = 3'b110; vbo_v = 1'b0;
    step();
    n_checks++;
    if (ram_re !== 1'b1 || ram_addr !== 15'd162 || wr_ack !== 1'b0)
      $display("FAIL slot_h8: got re=%b addr=%0d ack=%b exp 1/162/0", ram_re, ram_addr, wr_ack);
    else n_pass++;
    adv();
    step();
    n_checks++;
    if (wr_ack !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 15'd500)
      $display("FAIL host_h9: got ack=%b we=%b addr=%0d exp 1/1/500", wr_ack, ram_we, ram_addr);
    else n_pass++;
    adv();
    req_v = 1'b0;
    run(10);
  endtask

  task automatic test_vblank_only();
    int acks = 0;
    h = 0; v = 100; vbo_v = 1'b1; req_v = 1'b1; addr_v = 15'd1234; data_v = 3'b010;
    for (int i = 0; i < 40; i++) begin step(); if (wr_ack) acks++; adv(); end
    h = 780; v = 479;
    for (int i = 0; i < 20; i++) begin step(); if (wr_ack) acks++; adv(); end
    n_checks++;
    if (acks !== 0) $display("FAIL vblank_wait: got %0d acks exp 0", acks);
    else n_pass++;
    step();
    n_checks++;
    if (wr_ack !== 1'b1 || ram_we !== 1'b1 || h != 0 || v != 480)
      $display("FAIL vblank_grant h=%0d v=%0d: got ack=%b we=%b exp 1/1", h, v, wr_ack, ram_we);
    else n_pass++;
    adv();
    req_v = 1'b0; vbo_v = 1'b0;
    run(5);
  endtask

  task automatic test_oob();
    h = 10; v = 500; req_v = 1'b1; addr_v = 15'd19200; data_v = 3'b111;
    step();
    n_checks++;
    if (wr_ack !== 1'b1 || ram_we !== 1'b0)
      $display("FAIL oob_ack: got ack=%b we=%b exp 1/0", wr_ack, ram_we);
    else n_pass++;
    adv();
    req_v = 1'b0;
    step();
    n_checks++;
    if (oob_err !== 1'b1) $display("FAIL oob_set: got %b exp 1", oob_err);
    else n_pass++;
    adv();
    req_v = 1'b1; addr_v = 15'd19300; clr_v = 1'b1;
    step(); adv();
    req_v = 1'b0; clr_v = 1'b0;
    step();
    n_checks++;
    if (oob_err !== 1'b1) $display("FAIL oob_set_wins: got %b exp 1", oob_err);
    else n_pass++;
    adv();
    clr_v = 1'b1;
    step(); adv();
    clr_v = 1'b0;
    step();
    n_checks++;
    if (oob_err !== 1'b0) $display("FAIL oob_clear: got %b exp 0", oob_err);
    else n_pass++;
    adv();
    req_v = 1'b1; addr_v = 15'd19199; data_v = 3'b011;
    step(); adv();
    req_v = 1'b0;
    run(3);
  endtask

  task automatic test_sync_sweep();
    int hs_low = 0, vs_low = 0;
    h = 0; v = 488;
    for (int i = 0; i < 6 * 800; i++) begin
      step();
      if (!hsync) hs_low++;
      if (!vsync) vs_low++;
      adv();
    end
    n_checks++;
    if (hs_low != 6 * 96) $display("FAIL hsync_width: got %0d low cycles exp %0d", hs_low, 6 * 96);
    else n_pass++;
    n_checks++;
    if (vs_low != 1600) $display("FAIL vsync_width: got %0d low cycles exp 1600", vs_low);
    else n_pass++;
    h = 790; v = 524;
    run(30);
  endtask

  task automatic test_back_to_back();
    h = 0; v = 200; vbo_v = 1'b0; req_v = 1'b1;
    addr_v = 15'($urandom_range(0, 19199)); data_v = 3'($urandom_range(0, 7));
    for (int i = 0; i < 1200; i++) begin
      step();
      if (wr_ack) begin
        req_v  = ($urandom_range(0, 3) != 0);
        addr_v = ($urandom_range(0, 15) == 0) ? 15'($urandom_range(19200, 32767))
                                              : 15'($urandom_range(0, 19199));
        data_v = 3'($urandom_range(0, 7));
      end else if (!req_v) begin
        req_v = 1'b1;
      end
      adv();
    end
    req_v = 1'b0; clr_v = 1'b1;
    step(); adv();
    clr_v = 1'b0;
    run(5);
  endtask

  task automatic test_midline_reset();
    h = 296; v = 10;
    step(); adv();
    req_v = 1'b1; addr_v = 15'd20000;
    step(); adv();
    req_v = 1'b0;
    run(2);
    rst_v = 1'b0;
    step();
    n_checks++;
    if ({r, g, b} !== 3'b000 || hsync !== 1'b1 || vsync !== 1'b1 || oob_err !== 1'b0)
      $display("FAIL midline_reset: got rgb=%b hs=%b vs=%b oob=%b", {r, g, b}, hsync, vsync, oob_err);
    else n_pass++;
    adv();
    req_v = 1'b1; addr_v = 15'd777; data_v = 3'b001;
    step();
    n_checks++;
    if (wr_ack !== 1'b1 || ram_we !== 1'b1) $display("FAIL write_in_reset: got ack=%b we=%b exp 1/1", wr_ack, ram_we);
    else n_pass++;
    adv();
    req_v = 1'b0;
    while (h != 320) begin step(); adv(); end
    rst_v = 1'b1;
    run(400);
  endtask

  initial begin
    for (int a = 0; a < 19200; a++) mem[a] = 3'((a * 5 + a / 160) % 8);
    mem[0] = 3'b101;
    ram_rdata = 3'b000;
    cur_pix = 3'b000; exp_oob = 1'b0;
    h = 0; v = 0; req_v = 1'b0; vbo_v = 1'b0; clr_v = 1'b0; rst_v = 1'b0;
    addr_v = 15'd0; data_v = 3'b000;
    hcnt = 10'd0; vcnt = 10'd0; wr_req = 1'b0; wr_addr = 15'd0; wr_data = 3'b000;
    wr_vblank_only = 1'b0; oob_clr = 1'b0;
    rst = 1'b1;
    #1 rst = 1'b0;
    exp_q.push_back(RST_E);
    exp_q.push_back(RST_E);

    test_reset();
    test_display();
    test_slot_vs_host();
    test_vblank_only();
    test_oob();
    test_sync_sweep();
    test_back_to_back();
    test_midline_reset();

    @(negedge clk);
    n_checks++;
    if (wq.size() != 0) $display("FAIL pending_writes: %0d expected writes never reached RAM", wq.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/vga_vram_arbiter.md
VGA_VRAM_ARBITER -- requirements
Module: vga_vram_arbiter

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-003 SHALL have inputs hcnt and vcnt, each 10 bits, the raster position from the timing generator: hcnt 0..799, vcnt 0..524.
REQ-004 SHALL have host inputs wr_req (1), wr_addr (15), wr_data (3), wr_vblank_only (1), and host output wr_ack (1).
REQ-005 SHALL have RAM outputs ram_addr (15), ram_we (1), ram_re (1), ram_wdata (3), and RAM input ram_rdata (3) with 1-cycle read latency.
REQ-006 SHALL have display outputs hsync, vsync, r, g, b (1 each), and sticky status output oob_err (1) with clear input oob_clr (1).

Function
REQ-007 SHALL treat VRAM as a 160x120 framebuffer of 3-bit pixels; one pixel covers a 4x4 block of the 640x480 screen.
REQ-008 SHALL define active = (hcnt < 640) && (vcnt < 480).
REQ-009 SHALL define a display slot as a cycle with active && hcnt[1:0]==0; in a display slot: ram_re=1, ram_we=0, ram_addr = (vcnt>>2)*160 + (hcnt>>2).
REQ-010 SHALL reserve every display slot for display; host never gets a display slot.
REQ-011 SHALL define host-eligible cycles as all non-display-slot cycles when wr_vblank_only=0, and only cycles with vcnt >= 480 when wr_vblank_only=1.
REQ-012 In a host-eligible cycle with wr_req=1 and wr_addr < 19200, SHALL drive ram_we=1, ram_addr=wr_addr, ram_wdata=wr_data and wr_ack=1, all combinationally in the same cycle.
REQ-013 In a host-eligible cycle with wr_req=1 and wr_addr >= 19200, SHALL drive wr_ack=1 with ram_we=0 and set oob_err on the next edge.
REQ-014 SHALL hold wr_ack at 0 in every cycle that is not host-eligible, and in every cycle with wr_req=0.
REQ-015 Host contract: wr_req, wr_addr and wr_data SHALL stay stable until wr_ack; a request held across consecutive eligible cycles is acknowledged once per cycle (one write per cycle).
REQ-016 SHALL drive ram_re=0 and ram_we=0 in cycles with no display slot and no granted write; ram_addr is don't-care there.
REQ-017 SHALL latch ram_rdata into a pixel hold register on the edge ending the cycle after each display slot.
REQ-018 SHALL register r, g, b: {r,g,b} equals the pixel hold register when active was true 2 cycles earlier, else 3'b000.
REQ-019 SHALL register hsync low exactly when hcnt (2 cycles earlier) is in 656..751; SHALL register vsync low exactly when vcnt (2 cycles earlier) is in 490..491; both are high otherwise.
REQ-020 As a result, pixel data for screen column 4c appears on r/g/b 2 cycles after hcnt=4c and holds for 4 cycles, aligned with the delayed syncs.
REQ-021 SHALL clear oob_err when oob_clr=1; if oob_clr=1 and a set event occur in the same cycle, set wins.
REQ-022 SHALL handle hcnt/vcnt wrap (799->0, 524->0) with no extra state; the first display slot of a frame is hcnt=0, vcnt=0.

Reset
REQ-023 While rst=0: r=g=b=0, hsync=vsync=1, oob_err=0, pixel hold register=0, and both 2-stage delay pipelines are flushed to their blank/sync-high values.
REQ-024 Combinational outputs (ram_*, wr_ack) SHALL follow REQ-009..016 during reset; a write acknowledged while rst=0 still reaches RAM.
REQ-025 After release, the first valid r/g/b/sync values SHALL appear 2 edges later; no pipeline state from before reset may appear on the outputs.

Verification
REQ-026 hcnt=8, vcnt=4, wr_req=1 -> ram_re=1, ram_addr=162, wr_ack=0; at hcnt=9 -> wr_ack=1, ram_we=1, ram_addr=wr_addr.
REQ-027 ram_rdata=3'b101 after slot hcnt=0, vcnt=0 -> {r,g,b}=101 while hcnt is 2..5; 000 while hcnt is 642..799.
REQ-028 wr_vblank_only=1, wr_req=1 at vcnt=100 -> wr_ack stays 0 until vcnt=480, hcnt=0, then ack and write occur in that cycle.
REQ-029 wr_addr=19200 in an eligible cycle -> wr_ack=1, ram_we=0, oob_err=1 next cycle; oob_clr=1 together with a new OOB write -> oob_err stays 1.
REQ-030 Sweep a full frame -> hsync low 96 cycles per line starting 2 cycles after hcnt=656; vsync low for lines 490..491, delayed by 2 cycles.
REQ-031 Assert rst=0 mid-line at hcnt=300 -> outputs go to reset values immediately; after release, outputs match the reference model from 2 cycles later.
